cache_line_arbiter: RTL and testbench

Shares the single burst-memory port (bmem) between the instruction cache and the data cache once the core moves off magic memory. Accepts whole-line read/write requests from either cache, arbitrates round-robin, and serializes/deserializes each 256-bit line into four 64-bit bmem beats. Sits between the two cache memory-side ports and the `bmem_*` ports of the `mp4` top.

---
 rtl/cache_line_arbiter.sv | 146 ++++++++++++++
 tb/tb_cache_line_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_line_arbiter.sv
// cache_line_arbiter: shares one burst-memory port between the icache and dcache.
// Whole-line requests are arbitrated round-robin. Each line moves as BEATS beats of BEAT_W bits.
// LINE_W must be an integer multiple of BEAT_W.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | no transfer; arbitrate and latch the grant
// I_RD  | icache line read burst in progress
// D_RD  | dcache line read burst in progress
// D_WR  | dcache writeback burst in progress
// RESP  | one-cycle completion pulse to the granted side
module cache_line_arbiter #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       i_addr,
    input  logic              i_read,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic [31:0]       d_addr,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic [31:0]       bmem_address,
    output logic              bmem_read,
    output logic              bmem_write,
    input  logic [BEAT_W-1:0] bmem_rdata,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_resp
);

    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);
    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        I_RD = 3'd1,
        D_RD = 3'd2,
        D_WR = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t                        state_q;
    logic [CNT_W-1:0]              cnt_q;
    logic                          last_gnt_q;
    logic                          gnt_q;
    logic [31:0]                   addr_q;
    logic [BEATS-1:0][BEAT_W-1:0]  line_q;
    logic                          bmem_read_q;
    logic                          bmem_write_q;
    logic                          i_resp_q;
    logic                          d_resp_q;

    logic                          req_d;
    logic                          pick_d;
    logic [31:0]                   line_addr_d;
    logic                          unused_offset_bits;

    // Grant choice: a lone requester wins; on a tie the side that did not win last time wins.
    always_comb begin
        req_d       = d_read | d_write;
        pick_d      = req_d & (~i_read | (last_gnt_q == GNT_I));
        line_addr_d = pick_d ? {d_addr[31:OFF_W], {OFF_W{1'b0}}}
                             : {i_addr[31:OFF_W], {OFF_W{1'b0}}};
    end

    // Byte offset within a line never reaches memory.
    assign unused_offset_bits = ^{i_addr[OFF_W-1:0], d_addr[OFF_W-1:0]};

    // Arbitration, burst sequencing and completion pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_gnt_q   <= GNT_I;
            gnt_q        <= GNT_I;
            addr_q       <= '0;
            line_q       <= '0;
            bmem_read_q  <= 1'b0;
            bmem_write_q <= 1'b0;
            i_resp_q     <= 1'b0;
            d_resp_q     <= 1'b0;
        end else begin
            i_resp_q <= 1'b0;
            d_resp_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (i_read || req_d) begin
                        addr_q     <= line_addr_d;
                        cnt_q      <= '0;
                        last_gnt_q <= pick_d;
                        gnt_q      <= pick_d;
                        if (pick_d == GNT_I) begin
                            bmem_read_q <= 1'b1;
                            state_q     <= I_RD;
                        end else if (d_write) begin
                            // write wins over a simultaneous read
                            line_q       <= d_wdata;
                            bmem_write_q <= 1'b1;
                            state_q      <= D_WR;
                        end else begin
                            bmem_read_q <= 1'b1;
                            state_q     <= D_RD;
                        end
                    end
                end
                I_RD, D_RD, D_WR: begin
                    if (bmem_resp) begin
                        if (state_q != D_WR) begin
                            line_q[cnt_q] <= bmem_rdata;
                        end
                        if (cnt_q == CNT_LAST) begin
                            bmem_read_q  <= 1'b0;
                            bmem_write_q <= 1'b0;
                            i_resp_q     <= (gnt_q == GNT_I);
                            d_resp_q     <= (gnt_q == GNT_D);
                            state_q      <= RESP;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bmem_address = addr_q;
    assign bmem_read    = bmem_read_q;
    assign bmem_write   = bmem_write_q;
    assign bmem_wdata   = bmem_write_q ? line_q[cnt_q] : '0;
    assign i_rdata      = line_q;
    assign d_rdata      = line_q;
    assign i_resp       = i_resp_q;
    assign d_resp       = d_resp_q;

endmodule

// File: tb/tb_cache_line_arbiter.sv
// Testbench for cache_line_arbiter: per-cycle vector table plus directed sequences,
// with a response scoreboard for returned lines.
module tb_cache_line_arbiter;

    logic         clk;
    logic         rst;
    logic [31:0]  i_addr;
    logic         i_read;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic [31:0]  d_addr;
    logic         d_read;
    logic         d_write;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic [31:0]  bmem_address;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_rdata;
    logic [63:0]  bmem_wdata;
    logic         bmem_resp;

    int n_checks = 0;
    int n_fail   = 0;

    cache_line_arbiter #(.LINE_W(256), .BEAT_W(64)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .bmem_address(bmem_address), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_rdata(bmem_rdata), .bmem_wdata(bmem_wdata), .bmem_resp(bmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ir, dr, dw, br;
        logic [63:0] rdata;
        logic        e_rd, e_wr;
        logic [31:0] e_addr;
        logic [63:0] e_wdata;
        logic        e_ir, e_dr;
        logic        push;
    } vec_t;

    typedef struct {
        logic         is_d;
        logic         is_read;
        logic [255:0] line;
    } sb_t;

    sb_t  sb[$];
    vec_t tbl[$];

    function automatic vec_t v(input logic ir, dr, dw, br, input logic [63:0] rdata,
                               input logic e_rd, e_wr, input logic [31:0] e_addr,
                               input logic [63:0] e_wdata, input logic e_ir, e_dr, push);
        vec_t r;
        r.ir = ir; r.dr = dr; r.dw = dw; r.br = br; r.rdata = rdata;
        r.e_rd = e_rd; r.e_wr = e_wr; r.e_addr = e_addr; r.e_wdata = e_wdata;
        r.e_ir = e_ir; r.e_dr = e_dr; r.push = push;
        return r;
    endfunction

    function automatic logic [255:0] line_of(input logic [63:0] base);
        return {base + 64'd3, base + 64'd2, base + 64'd1, base};
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_sb(input logic is_d, input logic is_read, input logic [255:0] line);
        sb_t e;
        e.is_d = is_d; e.is_read = is_read; e.line = line;
        sb.push_back(e);
    endtask

    // Pop the oldest expected completion whenever a resp pulse is visible.
    task automatic sb_check();
        sb_t e;
        if (i_resp || d_resp) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_resp", {i_resp, d_resp}, 2'b00);
            end else begin
                e = sb.pop_front();
                check("sb_resp_side", {i_resp, d_resp}, e.is_d ? 2'b01 : 2'b10);
                if (e.is_read) check("sb_line", e.is_d ? d_rdata : i_rdata, e.line);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        sb_check();
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        bmem_resp = 1'b0; bmem_rdata = '0;
        sb.delete();
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        tick();
    endtask

    // Wait for a burst, check it, feed four back-to-back beats; returns in the RESP cycle.
    task automatic serve(input logic [31:0] exp_addr, input logic [63:0] base,
                         input logic exp_d, input logic exp_write, input logic [255:0] exp_line);
        logic seen;
        seen = 1'b0;
        for (int t = 0; t < 8 && !seen; t++) begin
            tick();
            seen = bmem_read | bmem_write;
        end
        check("req_seen", seen, 1'b1);
        check("req_addr", bmem_address, exp_addr);
        check("req_read", bmem_read, !exp_write);
        check("req_write", bmem_write, exp_write);
        for (int k = 0; k < 4; k++) begin
            if (exp_write) check("wr_beat", bmem_wdata, exp_line[k*64 +: 64]);
            bmem_resp  = 1'b1;
            bmem_rdata = base + 64'(k);
            tick();
        end
        bmem_resp = 1'b0;
        check("resp_i", i_resp, !exp_d);
        check("resp_d", d_resp, exp_d);
        check("req_dropped", bmem_read | bmem_write, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a_i, a_w;
        a_i = 32'h6000_0040;
        a_w = 32'h8000_0000;

        // single icache read, then gapped dcache writeback
        tbl.push_back(v(1,0,0,0,64'h0, 0,0,32'h0,64'h0, 0,0,1));
        tbl.push_back(v(1,0,0,0,64'h0, 1,0,a_i,64'h0, 0,0,0));
        tbl.push_back(v(1,0,0,1,64'h0, 1,0,a_i,64'h0, 0,0,0));
        tbl.push_back(v(1,0,0,1,64'h1, 1,0,a_i,64'h0, 0,0,0));
        tbl.push_back(v(1,0,0,1,64'h2, 1,0,a_i,64'h0, 0,0,0));
        tbl.push_back(v(1,0,0,1,64'h3, 1,0,a_i,64'h0, 0,0,0));
        tbl.push_back(v(1,0,0,0,64'h0, 0,0,a_i,64'h0, 1,0,0));
        tbl.push_back(v(0,0,0,0,64'h0, 0,0,a_i,64'h0, 0,0,0));
        tbl.push_back(v(0,0,1,0,64'h0, 0,0,a_i,64'h0, 0,0,1));
        tbl.push_back(v(0,0,1,1,64'h0, 0,1,a_w,64'hA, 0,0,0));
        tbl.push_back(v(0,0,1,0,64'h0, 0,1,a_w,64'hB, 0,0,0));
        tbl.push_back(v(0,0,1,1,64'h0, 0,1,a_w,64'hB, 0,0,0));
        tbl.push_back(v(0,0,1,1,64'h0, 0,1,a_w,64'hC, 0,0,0));
        tbl.push_back(v(0,0,1,0,64'h0, 0,1,a_w,64'hD, 0,0,0));
        tbl.push_back(v(0,0,1,1,64'h0, 0,1,a_w,64'hD, 0,0,0));
        tbl.push_back(v(0,0,1,0,64'h0, 0,0,a_w,64'h0, 0,1,0));
        tbl.push_back(v(0,0,0,0,64'h0, 0,0,a_w,64'h0, 0,0,0));

        i_addr  = 32'h6000_0044;
        d_addr  = 32'h8000_0010;
        d_wdata = {64'hD, 64'hC, 64'hB, 64'hA};
        apply_reset();
        check("reset_rdata", i_rdata, 256'h0);

        foreach (tbl[n]) begin
            check($sformatf("vec%0d_bmem_read", n),  bmem_read,    tbl[n].e_rd);
            check($sformatf("vec%0d_bmem_write", n), bmem_write,   tbl[n].e_wr);
            check($sformatf("vec%0d_bmem_addr", n),  bmem_address, tbl[n].e_addr);
            check($sformatf("vec%0d_bmem_wdata", n), bmem_wdata,   tbl[n].e_wdata);
            check($sformatf("vec%0d_i_resp", n),     i_resp,       tbl[n].e_ir);
            check($sformatf("vec%0d_d_resp", n),     d_resp,       tbl[n].e_dr);
            i_read = tbl[n].ir; d_read = tbl[n].dr; d_write = tbl[n].dw;
            bmem_resp = tbl[n].br; bmem_rdata = tbl[n].rdata;
            if (tbl[n].push)
                push_sb(tbl[n].dr | tbl[n].dw, !tbl[n].dw, {64'h3, 64'h2, 64'h1, 64'h0});
            tick();
        end

        // tie from reset: D first, then I; a repeated tie alternates again
        apply_reset();
        i_addr = 32'h1000_0024; d_addr = 32'h2000_0048;
        i_read = 1'b1; d_read = 1'b1;
        push_sb(1'b1, 1'b1, line_of(64'h100));
        push_sb(1'b0, 1'b1, line_of(64'h200));
        serve(32'h2000_0040, 64'h100, 1'b1, 1'b0, '0);
        d_read = 1'b0;
        serve(32'h1000_0020, 64'h200, 1'b0, 1'b0, '0);
        i_read = 1'b0;
        tick();
        i_read = 1'b1; d_read = 1'b1;
        push_sb(1'b1, 1'b1, line_of(64'h300));
        push_sb(1'b0, 1'b1, line_of(64'h400));
        serve(32'h2000_0040, 64'h300, 1'b1, 1'b0, '0);
        d_read = 1'b0;
        serve(32'h1000_0020, 64'h400, 1'b0, 1'b0, '0);
        i_read = 1'b0;

        // read and write together: write burst
        d_addr = 32'h3000_0000;
        d_wdata = {64'h44, 64'h33, 64'h22, 64'h11};
        d_read = 1'b1; d_write = 1'b1;
        push_sb(1'b1, 1'b0, '0);
        serve(32'h3000_0000, 64'h0, 1'b1, 1'b1, {64'h44, 64'h33, 64'h22, 64'h11});
        d_read = 1'b0; d_write = 1'b0;
        tick();

        // reset after two read beats
        i_addr = 32'h4000_0004;
        i_read = 1'b1;
        tick();
        check("rst_pre_read", bmem_read, 1'b1);
        bmem_resp = 1'b1; bmem_rdata = 64'hAA;
        tick();
        bmem_rdata = 64'hBB;
        tick();
        bmem_resp = 1'b0;
        check("rst_mid_read", bmem_read, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("rst_async_read", bmem_read, 1'b0);
        check("rst_async_addr", bmem_address, 32'h0);
        check("rst_async_iresp", i_resp, 1'b0);
        check("rst_async_line", i_rdata, 256'h0);
        i_read = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        tick();
        tick();
        check("rst_no_resp", {i_resp, d_resp}, 2'b00);
        i_read = 1'b1;
        push_sb(1'b0, 1'b1, line_of(64'h500));
        serve(32'h4000_0000, 64'h500, 1'b0, 1'b0, '0);
        i_read = 1'b0;
        tick();

        // stray memory responses while idle
        bmem_resp = 1'b1; bmem_rdata = 64'hDEAD;
        for (int t = 0; t < 3; t++) begin
            tick();
            check("stray_no_req", {bmem_read, bmem_write}, 2'b00);
            check("stray_no_resp", {i_resp, d_resp}, 2'b00);
        end
        bmem_resp = 1'b0;
        d_addr = 32'h5000_003F;
        d_read = 1'b1;
        push_sb(1'b1, 1'b1, line_of(64'h600));
        serve(32'h5000_0020, 64'h600, 1'b1, 1'b0, '0);
        d_read = 1'b0;
        tick();
        tick();

        check("sb_drain", 256'(sb.size()), 256'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
